// File: rtl/cordic_controller.sv
// Sequencer for the CORDIC vectoring datapath: load, quadrant pre-rotation, micro-rotations, optional degree conversion.
// Define CORDIC_DEG_CONV_EN to include the CONV state (z scaled to degrees before done).
module cordic_controller #(
  parameter int unsigned ITERATION_WIDTH = 4,
  parameter int unsigned NUM_ITERATIONS  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       load_x,
  output logic                       load_y,
  output logic                       load_z,
  output logic                       load_d,
  output logic                       load_d0,
  output logic                       clear_z,
  output logic [1:0]                 sel_x,
  output logic [1:0]                 sel_y,
  output logic [1:0]                 sel_z,
  output logic [ITERATION_WIDTH-1:0] iteration_counter
);

  localparam logic [ITERATION_WIDTH-1:0] LAST_ITER = ITERATION_WIDTH'(NUM_ITERATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SIGN0  = 3'd2,
    S_ROT90  = 3'd3,
    S_SIGN   = 3'd4,
    S_UPDATE = 3'd5,
    S_CONV   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   last_iter_c;

  logic       busy_d, done_d, load_x_d, load_y_d, load_z_d, load_d_d, load_d0_d, clear_z_d;
  logic [1:0] sel_x_d, sel_y_d, sel_z_d;

  assign last_iter_c = (iteration_counter == LAST_ITER);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = S_SIGN0;
      S_SIGN0:  state_d = S_ROT90;
      S_ROT90:  state_d = S_SIGN;
      S_SIGN:   state_d = S_UPDATE;
`ifdef CORDIC_DEG_CONV_EN
      S_UPDATE: state_d = last_iter_c ? S_CONV : S_SIGN;
      S_CONV:   state_d = S_DONE;
`else
      S_UPDATE: state_d = last_iter_c ? S_DONE : S_SIGN;
`endif
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state so the registered outputs line up with state_q
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    load_x_d  = 1'b0;
    load_y_d  = 1'b0;
    load_z_d  = 1'b0;
    load_d_d  = 1'b0;
    load_d0_d = 1'b0;
    clear_z_d = 1'b0;
    sel_x_d   = 2'd0;
    sel_y_d   = 2'd0;
    sel_z_d   = 2'd0;
    case (state_d)
      S_LOAD: begin
        busy_d    = 1'b1;
        load_x_d  = 1'b1;
        load_y_d  = 1'b1;
        clear_z_d = 1'b1;
      end
      S_SIGN0: begin
        busy_d    = 1'b1;
        load_d0_d = 1'b1;
      end
      S_ROT90: begin
        busy_d   = 1'b1;
        sel_x_d  = 2'd1;
        sel_y_d  = 2'd1;
        load_x_d = 1'b1;
        load_y_d = 1'b1;
        load_z_d = 1'b1;
      end
      S_SIGN: begin
        busy_d    = 1'b1;
        load_d_d  = 1'b1;
        load_d0_d = 1'b1;
      end
      S_UPDATE: begin
        busy_d   = 1'b1;
        sel_x_d  = 2'd2;
        sel_y_d  = 2'd2;
        sel_z_d  = 2'd1;
        load_x_d = 1'b1;
        load_y_d = 1'b1;
        load_z_d = 1'b1;
      end
`ifdef CORDIC_DEG_CONV_EN
      S_CONV: begin
        busy_d   = 1'b1;
        sel_z_d  = 2'd2;
        load_z_d = 1'b1;
      end
`endif
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      load_x  <= 1'b0;
      load_y  <= 1'b0;
      load_z  <= 1'b0;
      load_d  <= 1'b0;
      load_d0 <= 1'b0;
      clear_z <= 1'b0;
      sel_x   <= 2'd0;
      sel_y   <= 2'd0;
      sel_z   <= 2'd0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      load_x  <= load_x_d;
      load_y  <= load_y_d;
      load_z  <= load_z_d;
      load_d  <= load_d_d;
      load_d0 <= load_d0_d;
      clear_z <= clear_z_d;
      sel_x   <= sel_x_d;
      sel_y   <= sel_y_d;
      sel_z   <= sel_z_d;
    end
  end

  // Iteration index: cleared leaving LOAD, advanced leaving a non-final UPDATE, never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iteration_counter <= '0;
    end else if (state_q == S_LOAD) begin
      iteration_counter <= '0;
    end else if (state_q == S_UPDATE && !last_iter_c) begin
      iteration_counter <= iteration_counter + ITERATION_WIDTH'(1);
    end
  end

endmodule
